cpm_fifo_pack: RTL and testbench

Second-generation CPM FIFO with write-side width packing. It accepts narrow WR_WIDTH words, packs RATIO of them LSB-lane-first into one wide word, and stores the wide words in a DEPTH-entry circular buffer. It adds programmable almost-full and almost-empty levels, sticky overflow and underflow flags, a partial-word flush (push_last), and a choice of fall-through or registered read port. It sits between narrow producers (e.g. sample or byte streams) and wide CPM datapath consumers.

---
 rtl/cpm_fifo_pkg.sv | 18 +
 rtl/cpm_fifo_packer.sv | 66 ++++++
 rtl/cpm_fifo_pack.sv | 129 ++++++++++++
 tb/tb_cpm_fifo_pack.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpm_fifo_pkg.sv
// Shared definitions for the CPM packing FIFO.
//   lane_bits()        : width of a lane index for a given pack ratio (never below 1)
//   af_level_default() : default almost-full threshold, two entries below capacity
//   AE_LEVEL_DEFAULT   : default almost-empty threshold
package cpm_fifo_pkg;

  localparam int AE_LEVEL_DEFAULT  = 1;
  localparam int AF_MARGIN_DEFAULT = 2;

  function automatic int lane_bits(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int af_level_default(input int addr_width);
    return (1 << addr_width) - AF_MARGIN_DEFAULT;
  endfunction

endpackage

// File: rtl/cpm_fifo_packer.sv
// Write-side lane packer. Collects RATIO narrow words LSB-lane-first into one
// wide word and raises commit in the same cycle as the push that closes it.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous flush of the open pack word
//   accept       : a narrow word is accepted this cycle
//   last         : close the word after this lane (upper lanes stay zero)
//   data_in      : narrow write data
//   pack_level   : lanes already filled in the open word
//   commit       : the wide word is complete this cycle
//   commit_word  : the completed wide word (valid with commit)
module cpm_fifo_packer
  import cpm_fifo_pkg::*;
#(
  parameter int WR_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int LANE_W   = lane_bits(RATIO)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         accept,
  input  logic                         last,
  input  logic [WR_WIDTH-1:0]          data_in,
  output logic [LANE_W-1:0]            pack_level,
  output logic                         commit,
  output logic [WR_WIDTH*RATIO-1:0]    commit_word
);

  localparam int RD_WIDTH = WR_WIDTH * RATIO;
  localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(RATIO - 1);

  logic [RD_WIDTH-1:0] pack_reg;
  logic [RD_WIDTH-1:0] merged;

  // The pack register is zeroed on every commit, so lanes above the current
  // one are already zero and need no explicit padding here.
  always_comb begin
    merged = pack_reg;
    for (int i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) == pack_level) merged[i*WR_WIDTH +: WR_WIDTH] = data_in;
    end
  end

  // With RATIO=1 the only lane is also the top lane, so every push commits.
  assign commit      = accept && (last || (pack_level == TOP_LANE));
  assign commit_word = merged;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_reg   <= '0;
      pack_level <= '0;
    end else if (clear) begin
      pack_reg   <= '0;
      pack_level <= '0;
    end else if (commit) begin
      pack_reg   <= '0;
      pack_level <= '0;
    end else if (accept) begin
      pack_reg   <= merged;
      pack_level <= pack_level + 1'b1;
    end
  end

endmodule

// File: rtl/cpm_fifo_pack.sv
// CPM FIFO with write-side width packing. Narrow words are packed into wide
// words, which are stored in a DEPTH-entry circular buffer.
//   clk, rst       : clock, asynchronous active-high reset
//   Reset          : synchronous flush, wins over push/pop
//   push, push_last, data_in : narrow write port (push_last closes the word)
//   pop            : read request
//   data_out, data_valid     : wide read port (fall-through or registered)
//   empty, full, almost_full, almost_empty, fifo_count : occupancy status
//   pack_level     : lanes filled in the open pack word
//   overflow, underflow      : sticky error flags
module cpm_fifo_pack
  import cpm_fifo_pkg::*;
#(
  parameter int WR_WIDTH   = 8,
  parameter int RATIO      = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = af_level_default(ADDR_WIDTH),
  parameter int AE_LEVEL   = AE_LEVEL_DEFAULT,
  parameter bit REG_OUT    = 1'b0,
  parameter int LANE_W     = lane_bits(RATIO)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       push_last,
  input  logic [WR_WIDTH-1:0]        data_in,
  input  logic                       pop,
  output logic [WR_WIDTH*RATIO-1:0]  data_out,
  output logic                       data_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ADDR_WIDTH:0]        fifo_count,
  output logic [LANE_W-1:0]          pack_level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int RD_WIDTH = WR_WIDTH * RATIO;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  logic [RD_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  commit;
  logic [RD_WIDTH-1:0]   commit_word;

  assign empty        = (fifo_count == '0);
  assign full         = (fifo_count == (ADDR_WIDTH+1)'(DEPTH));
  assign almost_full  = (fifo_count >= (ADDR_WIDTH+1)'(AF_LEVEL));
  assign almost_empty = (fifo_count <= (ADDR_WIDTH+1)'(AE_LEVEL));

  // Gated by Reset so a flush cycle can neither pack nor pop.
  assign push_ok = push && !full && !Reset;
  assign pop_ok  = pop && !empty && !Reset;

  cpm_fifo_packer #(
    .WR_WIDTH (WR_WIDTH),
    .RATIO    (RATIO),
    .LANE_W   (LANE_W)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (Reset),
    .accept      (push_ok),
    .last        (push_last),
    .data_in     (data_in),
    .pack_level  (pack_level),
    .commit      (commit),
    .commit_word (commit_word)
  );

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers
  // and count, and leaving it out lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr] <= commit_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({commit, pop_ok})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && full) overflow  <= 1'b1;
      if (pop && empty) underflow <= 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out   <= '0;
          data_valid <= 1'b0;
        end else if (Reset) begin
          data_out   <= '0;
          data_valid <= 1'b0;
        end else begin
          data_valid <= pop_ok;
          if (pop_ok) data_out <= mem[rd_ptr];
        end
      end
    end else begin : g_fall_through
      assign data_out   = mem[rd_ptr];
      assign data_valid = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_cpm_fifo_pack.sv
// Bench for cpm_fifo_pack: a fall-through and a registered-output instance
// share one stimulus stream and are compared against a behavioural model.
module tb_cpm_fifo_pack;

  localparam int WW    = 8;
  localparam int RT    = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 2;
  localparam int AE    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        Reset;
  logic        push;
  logic        push_last;
  logic        pop;
  logic [7:0]  data_in;

  logic [31:0] ft_data_out, rg_data_out;
  logic        ft_valid, rg_valid;
  logic        ft_empty, rg_empty, ft_full, rg_full;
  logic        ft_af, rg_af, ft_ae, rg_ae;
  logic [2:0]  ft_count, rg_count;
  logic [1:0]  ft_level, rg_level;
  logic        ft_ovf, rg_ovf, ft_unf, rg_unf;

  always #5 clk = ~clk;

  cpm_fifo_pack #(.WR_WIDTH(WW), .RATIO(RT), .ADDR_WIDTH(AW), .REG_OUT(1'b0)) u_dut_ft (
    .clk(clk), .rst(rst), .Reset(Reset), .push(push), .push_last(push_last),
    .data_in(data_in), .pop(pop), .data_out(ft_data_out), .data_valid(ft_valid),
    .empty(ft_empty), .full(ft_full), .almost_full(ft_af), .almost_empty(ft_ae),
    .fifo_count(ft_count), .pack_level(ft_level), .overflow(ft_ovf), .underflow(ft_unf)
  );

  cpm_fifo_pack #(.WR_WIDTH(WW), .RATIO(RT), .ADDR_WIDTH(AW), .REG_OUT(1'b1)) u_dut_reg (
    .clk(clk), .rst(rst), .Reset(Reset), .push(push), .push_last(push_last),
    .data_in(data_in), .pop(pop), .data_out(rg_data_out), .data_valid(rg_valid),
    .empty(rg_empty), .full(rg_full), .almost_full(rg_af), .almost_empty(rg_ae),
    .fifo_count(rg_count), .pack_level(rg_level), .overflow(rg_ovf), .underflow(rg_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: committed wide words in order, plus the open pack word.
  logic [31:0] q[$];
  int          m_level;
  logic [31:0] m_pack;
  bit          m_ovf, m_unf, m_valid;
  logic [31:0] m_dout;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_level = 0;
    m_pack  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
  endtask

  task automatic check_state();
    int c;
    c = q.size();
    check("ft_count", ft_count, c);
    check("ft_empty", ft_empty, c == 0);
    check("ft_full", ft_full, c == DEPTH);
    check("ft_almost_full", ft_af, c >= AF);
    check("ft_almost_empty", ft_ae, c <= AE);
    check("ft_pack_level", ft_level, m_level);
    check("ft_overflow", ft_ovf, m_ovf);
    check("ft_underflow", ft_unf, m_unf);
    check("ft_data_valid", ft_valid, c != 0);
    check("rg_count", rg_count, c);
    check("rg_pack_level", rg_level, m_level);
    check("rg_overflow", rg_ovf, m_ovf);
    check("rg_underflow", rg_unf, m_unf);
    check("rg_data_valid", rg_valid, m_valid);
    check("rg_data_out", rg_data_out, m_dout);
  endtask

  // One clock: drive after the falling edge, check the fall-through head
  // before the rising edge, update the model, then check after the edge.
  task automatic cycle(input bit p, input bit pl, input logic [7:0] d, input bit pp, input bit rs);
    bit pop_ok, push_ok;
    @(negedge clk);
    push = p; push_last = pl; data_in = d; pop = pp; Reset = rs;
    #1;
    if (pp && !rs && q.size() > 0) check("ft_head", ft_data_out, q[0]);
    @(posedge clk);
    if (rs) begin
      model_clear();
    end else begin
      pop_ok  = pp && (q.size() > 0);
      push_ok = p && (q.size() < DEPTH);
      if (pp && !pop_ok) m_unf = 1'b1;
      if (p && !push_ok) m_ovf = 1'b1;
      m_valid = pop_ok;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) begin
        m_pack[m_level*8 +: 8] = d;
        if (m_level == RT-1 || pl) begin
          q.push_back(m_pack);
          m_pack  = '0;
          m_level = 0;
        end else begin
          m_level++;
        end
      end
    end
    #1 check_state();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; Reset = 1'b0; push = 1'b0; push_last = 1'b0; pop = 1'b0; data_in = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_state();
    check("rst_empty", ft_empty, 1'b1);
    check("rst_almost_empty", ft_ae, 1'b1);
    @(negedge clk) rst = 1'b0;

    // Four narrow pushes pack into one wide word, LSB lane first.
    cycle(1, 0, 8'h11, 0, 0); check("t1_level_a", ft_level, 2'd1);
    cycle(1, 0, 8'h22, 0, 0); check("t1_level_b", ft_level, 2'd2);
    cycle(1, 0, 8'h33, 0, 0); check("t1_level_c", ft_level, 2'd3);
    cycle(1, 0, 8'h44, 0, 0); check("t1_level_d", ft_level, 2'd0);
    check("t1_count", ft_count, 3'd1);
    check("t1_word", ft_data_out, 32'h44332211);

    // push_last on lane 0 commits a zero-padded word.
    cycle(1, 1, 8'hAA, 0, 0);
    check("t2_count", ft_count, 3'd2);
    do_pop(); check("t2_pop_a", rg_data_out, 32'h44332211);
    do_pop(); check("t2_pop_b", rg_data_out, 32'h000000AA);

    // Fill to full, overflow on the extra push, overflow survives a pop.
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i + 1), 0, 0);
    check("t3_full", ft_full, 1'b1);
    check("t3_af", ft_af, 1'b1);
    cycle(1, 0, 8'hEE, 0, 0);
    check("t3_overflow", ft_ovf, 1'b1);
    check("t3_count", ft_count, 3'd4);
    do_pop(); check("t3_ovf_sticky", ft_ovf, 1'b1);
    check("t3_pop_word", rg_data_out, 32'h04030201);
    repeat (3) do_pop();

    // Pop while empty sets underflow; read pointer must stay put.
    do_pop(); check("t4_underflow", ft_unf, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'(8'hC0 + i), 0, 0);
    check("t4_count", ft_count, 3'd1);
    do_pop(); check("t4_word", rg_data_out, 32'hC3C2C1C0);

    // Commit and pop in the same cycle leave the count unchanged.
    for (int i = 0; i < 11; i++) cycle(1, 0, 8'(8'h50 + i), 0, 0);
    check("t5_count_pre", ft_count, 3'd2);
    cycle(1, 0, 8'h5B, 1, 0);
    check("t5_count_same", ft_count, 3'd2);
    check("t5_valid_pulse", rg_valid, 1'b1);
    idle(); check("t5_valid_drop", rg_valid, 1'b0);
    repeat (2) do_pop();

    // Synchronous Reset beats push and pop.
    cycle(1, 0, 8'h01, 0, 0);
    cycle(1, 0, 8'h02, 0, 0);
    cycle(1, 0, 8'h03, 1, 1);
    check("t6_count", ft_count, 3'd0);
    check("t6_level", ft_level, 2'd0);
    check("t6_ovf", ft_ovf, 1'b0);
    check("t6_unf", ft_unf, 1'b0);
    check("t6_empty", ft_empty, 1'b1);

    // Asynchronous rst mid-cycle clears without a clock edge.
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h70 + i), 0, 0);
    do_pop(); do_pop();
    @(negedge clk);
    push = 1'b0; push_last = 1'b0; pop = 1'b0; Reset = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_state();
    check("t6_async_level", ft_level, 2'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check_state();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 8'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
